execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the EXM1 ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXM1 and iterates in the background.
- Raises a stall when a dependent HI/LO access, or a new mul/div op, arrives while an operation is in flight.
- Successor to the single-cycle ALU path: configurable width and multiply radix, adds sequential muldiv behaviour.

Parameters:
XLEN, 32, datapath width; must be even and >= 8
MUL_STEP, 2, multiplier bits retired per cycle; legal values 1, 2, 4; XLEN % MUL_STEP == 0
DIV_ZERO_LO, all ones, LO value written on divide by zero (width XLEN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush; aborts the in-flight op
Start_EXM1  in  1  valid muldiv/move op in EXM1, already qualified by AnyStall
Op_EXM1  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others illegal and ignored
SrcA_EXM1  in  XLEN  rs operand, post-bypass
SrcB_EXM1  in  XLEN  rt operand, post-bypass
HiLoRead_EXM1  in  1  MFHI/MFLO present in EXM1
MdStall_EXM1  out  1  stall request to hazard logic
Busy_EX  out  1  iteration in progress
Done_EX  out  1  one-cycle pulse when HI/LO first show a new mul/div result
Hi_EX  out  XLEN  HI register
Lo_EX  out  XLEN  LO register

Behaviour:
- Reset (async, rst_n low): state IDLE; Hi_EX, Lo_EX, all working registers = 0; Busy_EX = 0; Done_EX = 0; MdStall_EXM1 = 0.
- States:
  - IDLE -> MUL on Start with op 000/001.
  - IDLE -> DIV on Start with op 010/011.
  - MUL -> FIX after XLEN/MUL_STEP iterations.
  - DIV -> FIX after XLEN iterations.
  - FIX -> IDLE after one cycle.
- Capture at start: operand magnitudes, result sign flags, signed/unsigned mode.
  - Unsigned ops: operands taken as-is.
  - Signed ops: two's-complement magnitudes, XLEN-bit unsigned (most-negative maps to 2^(XLEN-1)).
- MUL: shift-add, MUL_STEP bits of the multiplier per cycle into a 2*XLEN accumulator.
- DIV: restoring, 1 quotient bit per cycle.
- FIX cycle: apply signs.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - At the FIX-cycle edge, {HI, LO} <= product, or HI <= remainder, LO <= quotient.
- Latency:
  - Busy_EX is high from the cycle after Start through the FIX cycle inclusive.
  - Defaults: MUL 16+1 = 17 cycles; DIV 32+1 = 33 cycles.
  - Done_EX is high in the first cycle HI/LO hold the result; Busy_EX is low that same cycle.
- MTHI/MTLO when idle: writes HI or LO at the next edge; no Busy_EX; no Done_EX.
- MdStall_EXM1 (combinational) = Busy_EX AND (HiLoRead_EXM1 OR Start_EXM1). A stalled Start is not accepted and must be re-presented.
- MFHI/MFLO when idle: no stall; reads the current Hi_EX/Lo_EX, which are registered outputs.
- Divide by zero: runs full DIV latency; HI = dividend (raw SrcA), LO = DIV_ZERO_LO; sign fixup is bypassed.
- Overflow (most-negative / -1, signed): LO = most-negative, HI = 0; this falls out of the magnitude algorithm.
- flush:
  - Any state -> IDLE next cycle.
  - HI/LO keep their pre-op values; no Done_EX.
  - A Start in the same cycle as flush is dropped; flush wins.
- flush in the FIX cycle: HI/LO not written.
- Illegal Op_EXM1 with Start: ignored; state unchanged; no stall.

Decomposition:
- Package execute_md_pkg:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state enum (IDLE, MUL, DIV, FIX)
- Sub-module md_div_step: combinational one-bit restoring-divide step (partial remainder, divisor -> next remainder, quotient bit).
- Multiply step, control FSM and HI/LO stay in execute_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 17 busy cycles: Hi = 0xFFFFFFFE, Lo = 0x00000001; Done one cycle.
- MULT -7 x 3 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. DIV -7 / 2 -> after 33 busy cycles: Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0. DIVU 5 / 0 -> Hi = 5, Lo = 0xFFFFFFFF.
- MULT issued, then HiLoRead_EXM1 held high -> MdStall_EXM1 = 1 every busy cycle; 0 in the Done cycle, when the read sees the new Lo.
- MTLO 0x1234 then MULTU 2 x 3, flush on busy cycle 5 -> Lo stays 0x1234; Busy drops the next cycle; no Done.
- Start MULTU with rst_n pulsed low mid-operation -> all outputs 0 immediately (async); state IDLE; subsequent op completes normally.

Source files
------------

// File: rtl/execute_md_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the mul/div unit.
package execute_md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Signed variants have op[0] clear; only meaningful for mul/div ops.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (md_is_mul(op) || md_is_div(op)) && !op[0];
    endfunction

endpackage

// File: rtl/execute_muldiv_div_step.sv
// One restoring-divide step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module md_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // With i_rem < i_divisor the borrow lands exactly in the top bit of w_diff.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle mul/div unit with architectural HI/LO, iterating beside the EXM1 ALU.
// Latency: MUL XLEN/MUL_STEP+1 cycles, DIV XLEN+1 cycles; MTHI/MTLO single edge.
// Backpressure: MdStall_EXM1 holds any HI/LO read or new op while busy; stalled ops re-presented.
module execute_muldiv
    import execute_md_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              MUL_STEP    = 2,
    parameter logic [XLEN-1:0] DIV_ZERO_LO = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            Start_EXM1,
    input  logic [2:0]      Op_EXM1,
    input  logic [XLEN-1:0] SrcA_EXM1,
    input  logic [XLEN-1:0] SrcB_EXM1,
    input  logic            HiLoRead_EXM1,
    output logic            MdStall_EXM1,
    output logic            Busy_EX,
    output logic            Done_EX,
    output logic [XLEN-1:0] Hi_EX,
    output logic [XLEN-1:0] Lo_EX
);

    localparam int MUL_ITERS = XLEN / MUL_STEP;
    localparam int CW        = $clog2(XLEN + 1);

    md_state_t         r_state;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opa;      // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   r_opb;      // multiplier shifting out, or divisor
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_raw_a;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_is_div;
    logic              r_div0;
    logic              r_done;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic                 w_busy;
    logic                 w_legal;
    logic                 w_signed;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [XLEN-1:0]      w_mag_a;
    logic [XLEN-1:0]      w_mag_b;
    logic [XLEN+MUL_STEP-1:0] w_pp;
    logic [XLEN+MUL_STEP-1:0] w_sum;
    logic [XLEN-1:0]      w_rem_nxt;
    logic                 w_qbit;
    logic [2*XLEN-1:0]    w_prod;
    logic [XLEN-1:0]      w_quo;
    logic [XLEN-1:0]      w_rem;

    assign w_busy   = (r_state != IDLE);
    assign w_legal  = (Op_EXM1 <= MD_MTLO);
    assign w_signed = md_is_signed(Op_EXM1);
    assign w_neg_a  = w_signed & SrcA_EXM1[XLEN-1];
    assign w_neg_b  = w_signed & SrcB_EXM1[XLEN-1];
    // Most-negative negates to itself, which reads correctly as 2^(XLEN-1) unsigned.
    assign w_mag_a  = w_neg_a ? -SrcA_EXM1 : SrcA_EXM1;
    assign w_mag_b  = w_neg_b ? -SrcB_EXM1 : SrcB_EXM1;

    assign w_pp  = {{MUL_STEP{1'b0}}, r_opa} * {{XLEN{1'b0}}, r_opb[MUL_STEP-1:0]};
    assign w_sum = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;

    md_div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_opa[XLEN-1]),
        .i_divisor (r_opb),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_opa : r_opa;
    assign w_rem  = r_neg_rem ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rem     <= '0;
            r_raw_a   <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_is_div  <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (Start_EXM1 && w_legal) begin
                        if (md_is_mul(Op_EXM1) || md_is_div(Op_EXM1)) begin
                            r_opa     <= w_mag_a;
                            r_opb     <= w_mag_b;
                            r_acc     <= '0;
                            r_rem     <= '0;
                            r_raw_a   <= SrcA_EXM1;
                            r_neg_res <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                            r_is_div  <= md_is_div(Op_EXM1);
                            r_div0    <= md_is_div(Op_EXM1) && (SrcB_EXM1 == '0);
                            r_cnt     <= md_is_div(Op_EXM1) ? CW'(XLEN - 1) : CW'(MUL_ITERS - 1);
                            r_state   <= md_is_div(Op_EXM1) ? DIV : MUL;
                        end else if (Op_EXM1 == MD_MTHI) begin
                            r_hi <= SrcA_EXM1;
                        end else begin
                            r_lo <= SrcA_EXM1;
                        end
                    end
                    MUL: begin
                        r_acc <= {w_sum, r_acc[XLEN-1:MUL_STEP]};
                        r_opb <= r_opb >> MUL_STEP;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) r_state <= FIX;
                    end
                    DIV: begin
                        r_rem <= w_rem_nxt;
                        r_opa <= {r_opa[XLEN-2:0], w_qbit};
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) r_state <= FIX;
                    end
                    FIX: begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        if (r_div0) begin
                            r_hi <= r_raw_a;
                            r_lo <= DIV_ZERO_LO;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*XLEN-1:XLEN];
                            r_lo <= w_prod[XLEN-1:0];
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign Busy_EX      = w_busy;
    assign Done_EX      = r_done;
    assign Hi_EX        = r_hi;
    assign Lo_EX        = r_lo;
    assign MdStall_EXM1 = w_busy & (HiLoRead_EXM1 | (Start_EXM1 & w_legal));

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: op-level reference model checked every cycle, plus directed literal cases.
module tb_execute_muldiv;

    localparam int XLEN     = 32;
    localparam int MUL_STEP = 2;
    localparam int MUL_LAT  = XLEN / MUL_STEP + 1;
    localparam int DIV_LAT  = XLEN + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        hlr   = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        md_stall, busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(XLEN), .MUL_STEP(MUL_STEP), .DIV_ZERO_LO(32'hFFFF_FFFF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .Start_EXM1    (start),
        .Op_EXM1       (op),
        .SrcA_EXM1     (a),
        .SrcB_EXM1     (b),
        .HiLoRead_EXM1 (hlr),
        .MdStall_EXM1  (md_stall),
        .Busy_EX       (busy),
        .Done_EX       (done),
        .Hi_EX         (hi),
        .Lo_EX         (lo)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} of a mul/div op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: r = 64'(sx * sy);
            3'd1: r = {32'b0, x} * {32'b0, y};
            3'd2: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
            3'd3: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_done = 1'b0;
    int          m_cnt  = 0;   // busy cycles still to come
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_cnt <= 0;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1: begin m_cnt <= MUL_LAT; m_pend <= ref_res(op, a, b); end
                    3'd2, 3'd3: begin m_cnt <= DIV_LAT; m_pend <= ref_res(op, a, b); end
                    3'd4: m_hi <= a;
                    3'd5: m_lo <= a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("hi",    64'(hi),       64'(m_hi));
        chk("lo",    64'(lo),       64'(m_lo));
        chk("busy",  64'(busy),     64'(m_cnt != 0));
        chk("done",  64'(done),     64'(m_done));
        chk("stall", 64'(md_stall), 64'((m_cnt != 0) && (hlr || (start && op <= 3'd5))));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic h,
                          input logic [31:0] eh, input logic [31:0] el, input int lat, input string nm);
        int n  = 0;
        int ns = 0;
        start = 1'b1; op = o; a = x; b = y; hlr = h;
        tick();
        start = 1'b0;
        while (busy && n < 200) begin
            n++;
            if (md_stall) ns++;
            tick();
        end
        chk({nm, "_lat"},  64'(n),    64'(lat));
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_hi"},   64'(hi),   64'(eh));
        chk({nm, "_lo"},   64'(lo),   64'(el));
        if (h) begin
            chk({nm, "_stall_cycles"}, 64'(ns),       64'(lat));
            chk({nm, "_stall_done"},   64'(md_stall), 64'd0);
        end
        hlr = 1'b0;
        tick();
        chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int nd;
        chk("ref_multu", ref_res(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_div",   ref_res(3'd2, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_ovf",   ref_res(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (2) tick();
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu_max");
        run_op(3'd0, 32'hFFFF_FFF9, 32'd3,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, "mult_neg");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_neg");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000, DIV_LAT, "div_ovf");
        run_op(3'd3, 32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF, DIV_LAT, "divu_zero");

        // Flush mid-multiply leaves HI/LO untouched and never pulses Done.
        start = 1'b1; op = 3'd5; a = 32'h1234;
        tick();
        start = 1'b0;
        chk("mtlo_lo",   64'(lo),   64'h1234);
        chk("mtlo_busy", 64'(busy), 64'd0);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        nd = 0;
        repeat (MUL_LAT + 2) begin
            if (done) nd++;
            tick();
        end
        chk("flush_no_done", 64'(nd), 64'd0);
        chk("flush_lo",      64'(lo), 64'h1234);
        chk("flush_hi",      64'(hi), 64'd5);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0; hlr = 1'b1;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi",    64'(hi),       64'd0);
        chk("arst_lo",    64'(lo),       64'd0);
        chk("arst_busy",  64'(busy),     64'd0);
        chk("arst_done",  64'(done),     64'd0);
        chk("arst_stall", 64'(md_stall), 64'd0);
        tick();
        rst_n = 1'b1; hlr = 1'b0;
        tick();
        run_op(3'd1, 32'd7, 32'd9, 1'b0, 32'd0, 32'd63, MUL_LAT, "multu_after_rst");

        // Random traffic, including stalled starts, illegal ops and flushes.
        repeat (4000) begin
            flush = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 3'($urandom_range(0, 7));
            a     = pick();
            b     = pick();
            hlr   = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0; flush = 1'b0; hlr = 1'b0;
        nd = 0;
        while (busy && nd < 100) begin
            nd++;
            tick();
        end
        chk("drain_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
